mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the CPU's single-ported 16-bit memory between three requesters:
//  instruction fetch (fetch phase), load/store (memory phase) and the
//  debug/loader port. Fixed priority: debug > data > fetch, with an aging
//  override that stops debug/data traffic from starving fetch. Runs a
//  req/ready transaction to memory with a timeout and reports done/err per
//  requester. Sits between the phase sequencer datapath and the memory.
// PARAMETERS
//  AW       16  address width
//  DW       16  data width
//  TIMEOUT  64  BUSY cycles with no mem_ready before abort; 0 = never abort
//  MAX_WAIT 4   lost arbitrations before fetch is forced to win; 0 = no aging
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     asynchronous, active-high
//  req        in   3     [0]=fetch [1]=data [2]=debug; held high until done/err
//  req_addr   in   3*AW  per-requester address, slice i = [i*AW +: AW]
//  req_we     in   3     per-requester write enable
//  req_wdata  in   3*DW  per-requester write data, slice i = [i*DW +: DW]
//  gnt        out  3     one-hot owner; high from the grant through the done/err cycle
//  done       out  3     1-cycle pulse to the owner, transaction completed
//  err        out  3     1-cycle pulse to the owner, transaction timed out
//  rdata      out  DW    read data; valid while done is high, held otherwise
//  busy       out  1     state != IDLE
//  mem_req    out  1     memory request, held until mem_ready or timeout
//  mem_addr   out  AW    latched address of the owner
//  mem_we     out  1     latched write enable of the owner
//  mem_wdata  out  DW    latched write data of the owner
//  mem_ready  in   1     memory accepts/completes in this cycle; ignored unless BUSY
//  mem_rdata  in   DW    read data, valid with mem_ready
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, including rdata and mem_*. Wait counter 0.
//   Timeout counter 0.
//  Reset mid-transaction: mem_req and gnt drop immediately. No done or err pulse.
//  Registered FSM with states IDLE, BUSY and DONE:
//   IDLE: if req != 0, choose a winner (see below) and latch its addr/we/wdata.
//    Next edge: gnt[w]=1, mem_req=1, go to BUSY, clear the timeout counter.
//   BUSY: hold mem_req and the latched mem_* outputs.
//    If mem_ready: rdata <= mem_rdata on reads only (writes leave rdata
//     unchanged), done[w]=1, drop mem_req, go to DONE.
//    Otherwise, if TIMEOUT != 0 and the counter reaches TIMEOUT-1: err[w]=1,
//     drop mem_req, go to DONE. rdata is unchanged.
//    Otherwise the counter increments.
//   DONE: done/err visible for exactly this cycle. gnt[w] still high.
//    req is not sampled. Next edge goes to IDLE and clears gnt.
//  Minimum latency: req sampled at edge 0 -> mem_req after edge 1 ->
//   mem_ready in that cycle -> done after edge 2. Each transaction costs
//   IDLE + >=1 BUSY + DONE.
//  Winner selection: if aging is enabled and wait_cnt == MAX_WAIT and req[0]
//   is high, fetch wins. Otherwise the highest set bit of {dbg, data, fetch} wins.
//  wait_cnt (3 bits, saturates at MAX_WAIT):
//   increments at an IDLE grant where req[0]=1 and fetch loses;
//   clears when fetch is granted, or at any IDLE cycle with req[0]=0.
//  Dropping req mid-transaction is ignored: the transaction completes and
//   done/err still pulse. A change to req_addr after the grant has no effect.
//  Simultaneous requests are resolved only in IDLE. Losers wait with req held.
// STRUCTURE
//  Shared package/header cpu16_defs: AW/DW defaults, REQ_FETCH=0,
//   REQ_DATA=1, REQ_DBG=2, and the state encodings ST_IDLE/ST_BUSY/ST_DONE.
//  Sub-module arb_pick: combinational priority picker with the aging
//   override, (req, age_hit) -> one-hot winner.
//  The FSM, counters and latches stay in the top module.
// TESTING
//  1 Fetch read: req=001, addr 0x0040; mem_ready 1 cycle after mem_req with
//    rdata 0xBEEF -> gnt=001, done=001 for 1 cycle, rdata=0xBEEF, busy=0.
//  2 Contention: req=111 in the same cycle -> debug served first, then data,
//    then fetch; grants 100, 010, 001 in order; every gap >= 1 IDLE cycle.
//  3 Aging with MAX_WAIT=4: data and fetch held high continuously -> data
//    wins 4 arbitrations, fetch wins the 5th, then wait_cnt clears.
//  4 Timeout with TIMEOUT=8: mem_ready never asserted -> mem_req high
//    exactly 8 cycles, then err[owner] pulses once and rdata is unchanged.
//  5 Write: data port we=1, wdata 0x1234, addr 0x8000 -> mem_we=1,
//    mem_wdata=0x1234, mem_addr=0x8000 held until mem_ready; done=010.
//  6 Reset asserted during BUSY -> mem_req, gnt and busy are 0 immediately;
//    no done/err. After release, a pending req is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU16 definitions: bus widths, requester indices and arbiter states.
package cpu16_defs;
    localparam int CPU_AW = 16;
    localparam int CPU_DW = 16;
    localparam int NREQ   = 3;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_DBG   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
interface mem_port_arbiter_if
    import cpu16_defs::*;
#(
    parameter int AW = CPU_AW,
    parameter int DW = CPU_DW
) ();
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0][AW-1:0] req_addr;
    logic [NREQ-1:0]         req_we;
    logic [NREQ-1:0][DW-1:0] req_wdata;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         done;
    logic [NREQ-1:0]         err;
    logic [DW-1:0]           rdata;
    logic                    busy;
    logic                    mem_req;
    logic [AW-1:0]           mem_addr;
    logic                    mem_we;
    logic [DW-1:0]           mem_wdata;
    logic                    mem_ready;
    logic [DW-1:0]           mem_rdata;

    modport slave (
        input  req, req_addr, req_we, req_wdata, mem_ready, mem_rdata,
        output gnt, done, err, rdata, busy, mem_req, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req, req_addr, req_we, req_wdata, mem_ready, mem_rdata,
        input  gnt, done, err, rdata, busy, mem_req, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Fixed-priority picker (debug > data > fetch) with a fetch aging override.
module arb_pick
    import cpu16_defs::*;
(
    input  logic [NREQ-1:0] i_req,
    input  logic            i_age_hit,
    output logic [NREQ-1:0] o_win
);
    always_comb begin
        o_win = '0;
        if (i_age_hit && i_req[REQ_FETCH])
            o_win[REQ_FETCH] = 1'b1;
        else if (i_req[REQ_DBG])
            o_win[REQ_DBG] = 1'b1;
        else if (i_req[REQ_DATA])
            o_win[REQ_DATA] = 1'b1;
        else if (i_req[REQ_FETCH])
            o_win[REQ_FETCH] = 1'b1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter for the single-ported CPU memory: one transaction at
// a time through IDLE -> BUSY -> DONE, with timeout and fetch anti-starvation.
module mem_port_arbiter
    import cpu16_defs::*;
#(
    parameter int AW       = CPU_AW,
    parameter int DW       = CPU_DW,
    parameter int TIMEOUT  = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int         TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0] MW = 3'(MAX_WAIT);

    arb_state_t      r_state, w_next;
    logic [NREQ-1:0] r_owner;
    logic            r_ok;
    logic [2:0]      r_wait;
    logic [TW-1:0]   r_tcnt;
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;

    logic [NREQ-1:0] w_win;
    logic            w_age_hit;
    logic            w_tmo;
    logic [AW-1:0]   w_sel_addr;
    logic            w_sel_we;
    logic [DW-1:0]   w_sel_wdata;

    assign w_age_hit = (MAX_WAIT != 0) && (r_wait == MW);
    assign w_tmo     = (TIMEOUT != 0) && (r_tcnt == TW'(TIMEOUT - 1));

    arb_pick u_pick (
        .i_req     (bus.req),
        .i_age_hit (w_age_hit),
        .o_win     (w_win)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win[i]) begin
                w_sel_addr  = w_sel_addr  | bus.req_addr[i];
                w_sel_we    = w_sel_we    | bus.req_we[i];
                w_sel_wdata = w_sel_wdata | bus.req_wdata[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (|bus.req) w_next = ST_BUSY;
            ST_BUSY: if (bus.mem_ready || w_tmo) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Owner latches, counters and read data; r_ok selects done vs err in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= '0;
            r_ok    <= 1'b0;
            r_wait  <= '0;
            r_tcnt  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        r_owner <= w_win;
                        r_addr  <= w_sel_addr;
                        r_we    <= w_sel_we;
                        r_wdata <= w_sel_wdata;
                        r_tcnt  <= '0;
                    end
                    if (!bus.req[REQ_FETCH] || w_win[REQ_FETCH])
                        r_wait <= '0;
                    else if (r_wait < MW)
                        r_wait <= r_wait + 3'd1;
                end
                ST_BUSY: begin
                    if (bus.mem_ready) begin
                        r_ok <= 1'b1;
                        if (!r_we) r_rdata <= bus.mem_rdata;
                    end else if (w_tmo) begin
                        r_ok <= 1'b0;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.gnt       = (r_state != ST_IDLE) ? r_owner : '0;
        bus.done      = (r_state == ST_DONE && r_ok)  ? r_owner : '0;
        bus.err       = (r_state == ST_DONE && !r_ok) ? r_owner : '0;
        bus.busy      = (r_state != ST_IDLE);
        bus.mem_req   = (r_state == ST_BUSY);
        bus.mem_addr  = r_addr;
        bus.mem_we    = r_we;
        bus.mem_wdata = r_wdata;
        bus.rdata     = r_rdata;
    end
endmodule
